// File: rtl/tff_bank_counter.sv
// tff_bank_counter: WIDTH-bit toggle/count/load register bank with modulo wrap and status flags
module tff_bank_counter #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    input  logic             clr,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             range_err
);
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH) || RESET_VAL >= MODULUS) begin : g_bad_param
        $error("tff_bank_counter: illegal WIDTH/MODULUS/RESET_VAL");
    end
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
    logic [WIDTH-1:0] q_q, q_d, tgl;
    logic             wrap_q, wrap_d, rerr_q, rerr_d, ovf_q, ovf_d, tgl_ok, d_ok;
    assign tgl    = q_q ^ t;
    assign tgl_ok = 64'(tgl) < MODULUS;
    assign d_ok   = 64'(d) < MODULUS;
    assign q      = q_q;
    assign qn     = ~q_q;
    assign wrap   = wrap_q;
    assign ovf    = ovf_q;
    assign range_err = rerr_q;
    assign tc     = en & ~clr & ((mode == 2'd1 && q_q == MAX) || (mode == 2'd2 && q_q == '0));
    // next-state selection: clr beats en, out-of-range results saturate to MODULUS-1
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        rerr_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            case (mode)
                2'd0: begin
                    q_d    = tgl_ok ? tgl : MAX;
                    rerr_d = ~tgl_ok;
                end
                2'd1: begin
                    q_d    = (q_q == MAX) ? '0 : q_q + 1'b1;
                    wrap_d = (q_q == MAX);
                end
                2'd2: begin
                    q_d    = (q_q == '0) ? MAX : q_q - 1'b1;
                    wrap_d = (q_q == '0);
                end
                2'd3: begin
                    q_d    = d_ok ? d : MAX;
                    rerr_d = ~d_ok;
                end
            endcase
        end
        ovf_d = wrap_d | (ovf_q & ~ovf_clr);
    end
    // state registers with asynchronous reset; pending pulses are dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= RST;
            wrap_q <= 1'b0;
            rerr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            rerr_q <= rerr_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_tff_bank_counter.sv
// tb_tff_bank_counter: scoreboard bench for tff_bank_counter at WIDTH=4, MODULUS=10
`timescale 1ns/1ps
module tb_tff_bank_counter;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, ovf_clr = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] t = 4'd0, d = 4'd0;
    logic [3:0] q, qn;
    logic       tc, wrap, ovf, range_err;
    typedef struct packed {
        logic [3:0] q;
        logic       tc, wrap, ovf, rerr;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    tff_bank_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .d(d),
        .clr(clr), .ovf_clr(ovf_clr), .q(q), .qn(qn), .tc(tc),
        .wrap(wrap), .ovf(ovf), .range_err(range_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // drive one cycle of stimulus and queue the response expected after the next edge
    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] tt, input logic [3:0] dd,
                        input logic c, input logic oc, input logic [3:0] eq,
                        input logic ew, input logic eo, input logic er);
        exp_t x;
        @(negedge clk);
        en = e; mode = m; t = tt; d = dd; clr = c; ovf_clr = oc;
        x.q    = eq;
        x.tc   = e & ~c & ((m == 2'd1 && eq == 4'd9) || (m == 2'd2 && eq == 4'd0));
        x.wrap = ew;
        x.ovf  = eo;
        x.rerr = er;
        sb.push_back(x);
    endtask

    // monitor: every post-edge sample is compared against the oldest queued expectation
    initial begin
        exp_t       x;
        logic [3:0] eqn;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x   = sb.pop_front();
                eqn = ~x.q;
                chk("q", q, x.q);
                chk("qn", qn, eqn);
                chk("tc", tc, x.tc);
                chk("wrap", wrap, x.wrap);
                chk("ovf", ovf, x.ovf);
                chk("range_err", range_err, x.rerr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_q", q, 4'd0);
        chk("rst_qn", qn, 4'hF);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_range_err", range_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++)
            step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'(i % 10), i == 10, i >= 10, 0);
        step(0, 2'd0, 4'd0, 4'd0, 1, 0, 4'd0, 0, 1, 0);
        step(1, 2'd2, 4'd0, 4'd0, 0, 0, 4'd9, 1, 1, 0);
        step(0, 2'd0, 4'd0, 4'd0, 1, 0, 4'd0, 0, 1, 0);
        step(1, 2'd2, 4'd0, 4'd0, 0, 1, 4'd9, 1, 1, 0);
        step(0, 2'd2, 4'd0, 4'd0, 0, 1, 4'd9, 0, 0, 0);
        step(1, 2'd3, 4'd0, 4'd5, 0, 0, 4'd5, 0, 0, 0);
        step(1, 2'd0, 4'hF, 4'd0, 0, 0, 4'd9, 0, 0, 1);
        step(1, 2'd0, 4'h3, 4'd0, 0, 0, 4'd9, 0, 0, 1);
        step(1, 2'd0, 4'h1, 4'd0, 0, 0, 4'd8, 0, 0, 0);
        step(1, 2'd0, 4'h0, 4'd0, 0, 0, 4'd8, 0, 0, 0);
        step(1, 2'd3, 4'd0, 4'd7, 0, 0, 4'd7, 0, 0, 0);
        step(1, 2'd3, 4'd0, 4'hF, 0, 0, 4'd9, 0, 0, 1);
        step(0, 2'd3, 4'd0, 4'd3, 0, 0, 4'd9, 0, 0, 0);
        step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'd0, 1, 1, 0);
        step(1, 2'd3, 4'd0, 4'd9, 0, 0, 4'd9, 0, 1, 0);
        step(1, 2'd1, 4'd0, 4'd0, 1, 0, 4'd0, 0, 1, 0);
        step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'd1, 0, 1, 0);
        step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'd2, 0, 1, 0);
        step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'd3, 0, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_q", q, 4'd0);
        chk("async_qn", qn, 4'hF);
        chk("async_wrap", wrap, 1'b0);
        chk("async_ovf", ovf, 1'b0);
        chk("async_range_err", range_err, 1'b0);
        chk("async_tc", tc, 1'b0);
        en = 1'b0;
        #1;
        rst_n = 1'b1;
        step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'd1, 0, 0, 0);
        step(1, 2'd1, 4'd0, 4'd0, 0, 0, 4'd2, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tff_bank_counter.md
Name: tff_bank_counter

Overview:
- Parametrised successor to the single toggle flip-flop: a WIDTH-bit register bank with four selectable modes.
- Modes: per-bit toggle, modulo up-count, modulo down-count, parallel load.
- Provides complementary outputs, a terminal-count flag, a wrap pulse, a sticky overflow flag and a range-error pulse.
- Used as a general counter/divider and toggle-register primitive in the memory-elements library.

Parameters:
WIDTH, 8, register width in bits (1..32)
MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH
RESET_VAL, 0, value of q after reset; must be < MODULUS

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  operation enable; when low the register holds
mode  input  2  0=toggle, 1=count up, 2=count down, 3=load
t  input  WIDTH  per-bit toggle mask (mode 0)
d  input  WIDTH  parallel load data (mode 3)
clr  input  1  synchronous clear to 0
ovf_clr  input  1  synchronous clear of the sticky ovf flag
q  output  WIDTH  register value
qn  output  WIDTH  bitwise complement of q
tc  output  1  terminal count (combinational)
wrap  output  1  registered one-cycle pulse on wrap-around
ovf  output  1  sticky overflow flag
range_err  output  1  registered one-cycle pulse on out-of-range result

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, regardless of clk): q=RESET_VAL, qn=~RESET_VAL, wrap=0, ovf=0, range_err=0.
- qn is always exactly ~q, including during reset; no cycle exists where qn != ~q.
- Update priority on each rising clk edge: rst_n > clr > en.
- clr=1: q<=0 irrespective of en and mode. wrap<=0, range_err<=0. ovf is unaffected by clr.
- en=0 and clr=0: q holds; wrap<=0; range_err<=0.
- en=1, mode 0 (toggle): next=q^t.
  - If next<MODULUS: q<=next.
  - Else: q<=MODULUS-1 and range_err<=1.
  - With t=0, q holds.
- en=1, mode 1 (count up):
  - If q==MODULUS-1: q<=0 and wrap<=1.
  - Else: q<=q+1.
- en=1, mode 2 (count down):
  - If q==0: q<=MODULUS-1 and wrap<=1.
  - Else: q<=q-1.
- en=1, mode 3 (load):
  - If d<MODULUS: q<=d.
  - Else: q<=MODULUS-1 and range_err<=1.
- wrap and range_err stay high for exactly one cycle per event. They are 0 in any cycle without a new event.
- tc = en & ~clr & ((mode==1 & q==MODULUS-1) | (mode==2 & q==0)). It is combinational and high in the cycle before a wrap.
- ovf:
  - Set on any edge where wrap is set.
  - Cleared on an edge where ovf_clr=1 and no wrap occurs.
  - If wrap and ovf_clr occur on the same edge, set wins.
- Arithmetic is at WIDTH bits. MODULUS=2**WIDTH gives natural binary wrap, and range_err can never fire.
- A reset asserted mid-operation aborts immediately; any pending wrap or range_err pulse is lost.
- On reset release, the first edge evaluates normally. There is no dead cycle.
- Elaboration: an illegal MODULUS or RESET_VAL must be flagged by an error check.

Test Plan:
- WIDTH=4, MODULUS=10: reset then en=1, mode=1 for 12 clocks -> q=1,2,...,9,0,1,2. tc high while q=9. wrap pulses once on the 9->0 edge. ovf=1 afterwards. qn=~q throughout.
- Down count from q=0, mode=2, en=1 -> q=9 next edge, wrap=1 for one cycle. ovf_clr=1 on the same edge as a second wrap -> ovf stays 1. ovf_clr alone -> ovf=0.
- Toggle mode, q=0101, t=1111 -> next=1010 (10>=MODULUS), so q=1001 and range_err pulses. Then t=0011 -> q=1010 is out of range again -> q=9, range_err pulses. Then t=0001 from q=1001 -> q=1000, no error.
- Load d=7 -> q=7. Load d=15 -> q=9 with range_err=1. en=0 with mode=3, d=3 -> q holds 9.
- clr=1 together with en=1, mode=1 at q=9 -> q=0, wrap=0, ovf unchanged.
- rst_n pulsed low between clock edges while counting -> q=RESET_VAL immediately (asynchronously), flags 0. Count resumes on the first edge after release.
